rename_table_ckpt: RTL and testbench

Speculative register rename table with checkpoint-based branch recovery. It succeeds the single-snapshot table, which restored to committed state on mispredict and relied on ROB replay. This block keeps NUM_CKPT snapshots of the speculative map, taken in a circular buffer at branch issue, so a mispredict restores the map in one cycle. It sits between decode/rename (lookup, issue), ROB (commit, flush) and the writeback buses (tag availability).

---
 rtl/rename_table_ckpt_pkg.sv | 14 +
 rtl/rename_table_ckpt_store.sv | 57 +++++
 rtl/rename_table_ckpt.sv | 116 +++++++++++
 tb/tb_rename_table_ckpt.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_table_ckpt_pkg.sv
// rename_table_ckpt_pkg: shared sizes and types for the checkpointed rename table.
package rename_table_ckpt_pkg;
  localparam int TAG_SIZE = 7;
  localparam int NUM_REGS = 32;
  localparam int ID_SIZE = $clog2(NUM_REGS);
  localparam int NUM_CKPT = 4;
  localparam int CKPT_W = $clog2(NUM_CKPT);
  localparam int NUM_PHYS = 1 << (TAG_SIZE - 1);
  typedef logic [TAG_SIZE-1:0] Tag;
  typedef logic [CKPT_W-1:0] CkptID;
  typedef logic [CKPT_W:0] CkptCnt;
  typedef logic [ID_SIZE-1:0] RegID;
  localparam Tag TAG_ZERO = {1'b1, {(TAG_SIZE-1){1'b0}}};
endpackage

// File: rtl/rename_table_ckpt_store.sv
// rename_ckpt_store: circular buffer of map snapshots with save, restore and free.
module rename_ckpt_store
  import rename_table_ckpt_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_save,
  input  Tag    i_save_data [NUM_REGS],
  input  logic  i_free,
  input  logic  i_restore,
  input  CkptID i_restore_id,
  input  logic  i_discard,
  output Tag    o_restore_data [NUM_REGS],
  output CkptID o_tail,
  output logic  o_full
);
  Tag r_ckpt [NUM_CKPT][NUM_REGS];
  CkptID r_head, r_tail;
  CkptCnt r_count;
  logic w_save_ok;
  CkptID w_head_nxt, w_offset;
  assign o_full = r_count == CkptCnt'(NUM_CKPT);
  assign o_tail = r_tail;
  assign w_save_ok = i_save & !o_full;
  assign w_head_nxt = r_head + CkptID'(i_free);
  assign w_offset = i_restore_id - r_head;
  always_comb
    for (int r = 0; r < NUM_REGS; r++) o_restore_data[r] = r_ckpt[i_restore_id][r];
  always_ff @(posedge clk)
    if (w_save_ok)
      for (int r = 0; r < NUM_REGS; r++) r_ckpt[r_tail][r] <= i_save_data[r];
  // restore keeps head..restore_id, i.e. offset+1 entries, minus a same-cycle free
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      r_head <= w_head_nxt;
      if (i_restore) begin
        r_tail <= i_restore_id + CkptID'(1);
        r_count <= CkptCnt'(w_offset) + CkptCnt'(1) - CkptCnt'(i_free);
      end else if (i_discard) begin
        r_tail <= w_head_nxt;
        r_count <= '0;
      end else begin
        r_tail <= r_tail + CkptID'(w_save_ok);
        r_count <= r_count + CkptCnt'(w_save_ok) - CkptCnt'(i_free);
      end
    end
  always @(posedge clk)
    if (!rst) begin
      assert (!(i_save && o_full));
      assert (!i_free || r_count != '0);
      assert (!i_restore || CkptCnt'(w_offset) < r_count);
    end
endmodule

// File: rtl/rename_table_ckpt.sv
// rename_table_ckpt: speculative rename map with single-cycle checkpoint restore on mispredict.
module rename_table_ckpt
  import rename_table_ckpt_pkg::*;
#(
  parameter int NUM_LOOKUP = 8,
  parameter int NUM_ISSUE = 4,
  parameter int NUM_COMMIT = 4,
  parameter int NUM_WB = 4
)(
  input  logic clk,
  input  logic rst,
  input  logic IN_mispred,
  input  logic IN_mispredFlush,
  input  logic IN_restoreValid,
  input  CkptID IN_restoreID,
  input  RegID IN_lookupIDs [NUM_LOOKUP],
  output logic [NUM_LOOKUP-1:0] OUT_lookupAvail,
  output Tag OUT_lookupSpecTag [NUM_LOOKUP],
  input  logic [NUM_ISSUE-1:0] IN_issueValid,
  input  RegID IN_issueIDs [NUM_ISSUE],
  input  Tag IN_issueTags [NUM_ISSUE],
  input  logic [NUM_ISSUE-1:0] IN_issueAvail,
  input  logic IN_ckptSave,
  input  logic [$clog2(NUM_ISSUE)-1:0] IN_ckptSaveSlot,
  output CkptID OUT_ckptID,
  output logic OUT_ckptFull,
  input  logic IN_ckptFree,
  input  logic [NUM_COMMIT-1:0] IN_commitValid,
  input  RegID IN_commitIDs [NUM_COMMIT],
  input  Tag IN_commitTags [NUM_COMMIT],
  output Tag OUT_commitPrevTags [NUM_COMMIT],
  input  logic [NUM_WB-1:0] IN_wbValid,
  input  Tag IN_wbTag [NUM_WB]
);
  Tag r_com_tag [NUM_REGS];
  Tag r_spec_tag [NUM_REGS];
  logic [NUM_PHYS-1:0] r_tag_avail;
  Tag w_save_data [NUM_REGS];
  Tag w_restore_data [NUM_REGS];
  Tag w_spec_nxt [NUM_REGS];
  Tag w_com_nxt [NUM_REGS];
  logic [NUM_PHYS-1:0] w_avail_nxt;
  logic w_restore, w_discard, w_com_to_spec;
  assign w_restore = IN_mispred & IN_restoreValid;
  assign w_discard = IN_mispred & !IN_restoreValid;
  assign w_com_to_spec = IN_mispredFlush ? !IN_mispred : w_discard;
  rename_ckpt_store u_store (
    .clk(clk),
    .rst(rst),
    .i_save(IN_ckptSave & !IN_mispred),
    .i_save_data(w_save_data),
    .i_free(IN_ckptFree),
    .i_restore(w_restore),
    .i_restore_id(IN_restoreID),
    .i_discard(w_discard),
    .o_restore_data(w_restore_data),
    .o_tail(OUT_ckptID),
    .o_full(OUT_ckptFull)
  );
  // older issue slots of the same cycle bypass the table; the youngest match wins
  always_comb
    for (int i = 0; i < NUM_LOOKUP; i++) begin
      OUT_lookupSpecTag[i] = r_spec_tag[IN_lookupIDs[i]];
      OUT_lookupAvail[i] = r_tag_avail[OUT_lookupSpecTag[i][TAG_SIZE-2:0]] | OUT_lookupSpecTag[i][TAG_SIZE-1];
      for (int w = 0; w < NUM_WB; w++)
        if (IN_wbValid[w] && IN_wbTag[w] == OUT_lookupSpecTag[i]) OUT_lookupAvail[i] = 1'b1;
      for (int j = 0; j < NUM_ISSUE; j++)
        if (j < i / 2 && IN_issueValid[j] && IN_issueIDs[j] == IN_lookupIDs[i] && IN_lookupIDs[i] != '0) begin
          OUT_lookupSpecTag[i] = IN_issueTags[j];
          OUT_lookupAvail[i] = IN_issueAvail[j] | IN_issueTags[j][TAG_SIZE-1];
        end
    end
  always_comb
    for (int k = 0; k < NUM_COMMIT; k++) begin
      OUT_commitPrevTags[k] = r_com_tag[IN_commitIDs[k]];
      for (int m = 0; m < k; m++)
        if (IN_commitValid[m] && IN_commitIDs[m] == IN_commitIDs[k] && IN_commitIDs[k] != '0)
          OUT_commitPrevTags[k] = IN_commitTags[m];
    end
  always_comb begin
    w_save_data = r_spec_tag;
    w_spec_nxt = r_spec_tag;
    w_com_nxt = r_com_tag;
    w_avail_nxt = r_tag_avail;
    for (int w = 0; w < NUM_WB; w++)
      if (IN_wbValid[w] && !IN_wbTag[w][TAG_SIZE-1]) w_avail_nxt[IN_wbTag[w][TAG_SIZE-2:0]] = 1'b1;
    for (int j = 0; j < NUM_ISSUE; j++)
      if (!IN_mispred && IN_issueValid[j]) begin
        if (IN_issueIDs[j] != '0) begin
          w_spec_nxt[IN_issueIDs[j]] = IN_issueTags[j];
          if (j <= int'(IN_ckptSaveSlot)) w_save_data[IN_issueIDs[j]] = IN_issueTags[j];
        end
        if (!IN_issueTags[j][TAG_SIZE-1]) w_avail_nxt[IN_issueTags[j][TAG_SIZE-2:0]] = 1'b0;
      end
    if (w_restore) w_spec_nxt = w_restore_data;
    if (w_discard) w_spec_nxt = r_com_tag;
    for (int k = 0; k < NUM_COMMIT; k++)
      if (IN_commitValid[k] && IN_commitIDs[k] != '0) begin
        if (!IN_mispredFlush) w_com_nxt[IN_commitIDs[k]] = IN_commitTags[k];
        if (w_com_to_spec) w_spec_nxt[IN_commitIDs[k]] = IN_commitTags[k];
      end
    w_spec_nxt[0] = TAG_ZERO;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_com_tag[r] <= TAG_ZERO;
        r_spec_tag[r] <= TAG_ZERO;
      end
      r_tag_avail <= '1;
    end else begin
      r_com_tag <= w_com_nxt;
      r_spec_tag <= w_spec_nxt;
      r_tag_avail <= w_avail_nxt;
    end
endmodule

// File: tb/tb_rename_table_ckpt.sv
// tb_rename_table_ckpt: random and directed stimulus against a queue-based rename/checkpoint model.
module tb_rename_table_ckpt;
  import rename_table_ckpt_pkg::*;
  localparam int NL = 8, NI = 4, NC = 4, NW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic mispred, flush, restore_v, save, free;
  CkptID restore_id, ckpt_id;
  logic [1:0] save_slot;
  logic full;
  RegID lk_id [NL];
  logic [NL-1:0] lk_av;
  Tag lk_tag [NL];
  logic [NI-1:0] is_v, is_av;
  RegID is_id [NI];
  Tag is_tag [NI];
  logic [NC-1:0] cm_v;
  RegID cm_id [NC];
  Tag cm_tag [NC];
  Tag cm_prev [NC];
  logic [NW-1:0] wb_v;
  Tag wb_tag [NW];
  always #5 clk = ~clk;
  rename_table_ckpt dut (
    .clk(clk), .rst(rst),
    .IN_mispred(mispred), .IN_mispredFlush(flush), .IN_restoreValid(restore_v), .IN_restoreID(restore_id),
    .IN_lookupIDs(lk_id), .OUT_lookupAvail(lk_av), .OUT_lookupSpecTag(lk_tag),
    .IN_issueValid(is_v), .IN_issueIDs(is_id), .IN_issueTags(is_tag), .IN_issueAvail(is_av),
    .IN_ckptSave(save), .IN_ckptSaveSlot(save_slot), .OUT_ckptID(ckpt_id), .OUT_ckptFull(full),
    .IN_ckptFree(free),
    .IN_commitValid(cm_v), .IN_commitIDs(cm_id), .IN_commitTags(cm_tag), .OUT_commitPrevTags(cm_prev),
    .IN_wbValid(wb_v), .IN_wbTag(wb_tag)
  );
  // model: plain maps plus a queue of live checkpoint IDs, oldest first
  Tag m_com [NUM_REGS];
  Tag m_spec [NUM_REGS];
  logic [NUM_PHYS-1:0] m_avail;
  Tag m_snap [NUM_CKPT][NUM_REGS];
  int m_ids [$];
  int m_tail;
  int n_vec = 0, n_err = 0;
  bit chk_en = 0;
  task automatic cmp(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_com[r] = TAG_ZERO;
      m_spec[r] = TAG_ZERO;
    end
    m_avail = '1;
    m_ids.delete();
    m_tail = 0;
  endtask
  task automatic model_lookup(input int i, output Tag t, output logic a);
    t = m_spec[lk_id[i]];
    a = t[6] || m_avail[t[5:0]];
    for (int w = 0; w < NW; w++) if (wb_v[w] && wb_tag[w] == t) a = 1'b1;
    for (int j = 0; j < i / 2; j++)
      if (is_v[j] && is_id[j] == lk_id[i] && lk_id[i] != 0) begin
        t = is_tag[j];
        a = is_av[j] | t[6];
      end
  endtask
  task automatic model_step();
    Tag ns [NUM_REGS];
    Tag sv [NUM_REGS];
    logic [NUM_PHYS-1:0] nav;
    ns = m_spec;
    sv = m_spec;
    nav = m_avail;
    for (int w = 0; w < NW; w++) if (wb_v[w] && !wb_tag[w][6]) nav[wb_tag[w][5:0]] = 1'b1;
    if (!mispred) begin
      for (int j = 0; j < NI; j++)
        if (is_v[j]) begin
          if (is_id[j] != 0) begin
            ns[is_id[j]] = is_tag[j];
            if (j <= int'(save_slot)) sv[is_id[j]] = is_tag[j];
          end
          if (!is_tag[j][6]) nav[is_tag[j][5:0]] = 1'b0;
        end
      if (save && m_ids.size() < NUM_CKPT) begin
        for (int r = 0; r < NUM_REGS; r++) m_snap[m_tail][r] = sv[r];
        m_ids.push_back(m_tail);
        m_tail = (m_tail + 1) % NUM_CKPT;
      end
    end
    if (free && m_ids.size() > 0) void'(m_ids.pop_front());
    if (mispred && restore_v) begin
      while (m_ids.size() > 0 && m_ids[$] != int'(restore_id)) void'(m_ids.pop_back());
      m_tail = (int'(restore_id) + 1) % NUM_CKPT;
      for (int r = 0; r < NUM_REGS; r++) ns[r] = m_snap[restore_id][r];
      ns[0] = TAG_ZERO;
    end else if (mispred) begin
      m_tail = (m_tail - m_ids.size() + NUM_CKPT) % NUM_CKPT;
      m_ids.delete();
      ns = m_com;
    end
    for (int k = 0; k < NC; k++)
      if (cm_v[k] && cm_id[k] != 0) begin
        if (!flush) m_com[cm_id[k]] = cm_tag[k];
        if (flush ? !mispred : (mispred && !restore_v)) ns[cm_id[k]] = cm_tag[k];
      end
    m_spec = ns;
    m_avail = nav;
  endtask
  always @(negedge clk)
    if (chk_en) begin
      Tag t;
      logic a;
      Tag tmp [NUM_REGS];
      cmp("ckptID", int'(ckpt_id), m_tail);
      cmp("ckptFull", int'(full), int'(m_ids.size() == NUM_CKPT));
      for (int i = 0; i < NL; i++) begin
        model_lookup(i, t, a);
        cmp($sformatf("lk%0d_tag", i), int'(lk_tag[i]), int'(t));
        cmp($sformatf("lk%0d_avail", i), int'(lk_av[i]), int'(a));
      end
      tmp = m_com;
      for (int k = 0; k < NC; k++)
        if (cm_v[k]) begin
          cmp($sformatf("prev%0d", k), int'(cm_prev[k]), int'(tmp[cm_id[k]]));
          if (cm_id[k] != 0) tmp[cm_id[k]] = cm_tag[k];
        end
    end
  task automatic clear_in();
    mispred = 0; flush = 0; restore_v = 0; restore_id = '0;
    save = 0; save_slot = '0; free = 0;
    is_v = '0; is_av = '0; cm_v = '0; wb_v = '0;
    for (int i = 0; i < NL; i++) lk_id[i] = '0;
    for (int j = 0; j < NI; j++) begin is_id[j] = '0; is_tag[j] = '0; end
    for (int k = 0; k < NC; k++) begin cm_id[k] = '0; cm_tag[k] = '0; end
    for (int w = 0; w < NW; w++) wb_tag[w] = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask
  task automatic rand_in();
    clear_in();
    for (int i = 0; i < NL; i++) lk_id[i] = RegID'($urandom_range(0, 7));
    for (int j = 0; j < NI; j++) begin
      is_v[j] = $urandom_range(0, 1) == 1;
      is_id[j] = RegID'($urandom_range(0, 7));
      is_tag[j] = ($urandom_range(0, 3) == 0) ? Tag'(32'h40 | $urandom_range(0, 63)) : Tag'($urandom_range(0, 63));
      is_av[j] = is_tag[j][6];
    end
    for (int k = 0; k < NC; k++) begin
      cm_v[k] = $urandom_range(0, 1) == 1;
      cm_id[k] = RegID'($urandom_range(0, 7));
      cm_tag[k] = Tag'($urandom_range(0, 127));
    end
    for (int w = 0; w < NW; w++) begin
      wb_v[w] = $urandom_range(0, 1) == 1;
      wb_tag[w] = Tag'($urandom_range(0, 63));
    end
    mispred = $urandom_range(0, 15) == 0;
    flush = $urandom_range(0, 7) == 0;
    if (m_ids.size() > 0 && $urandom_range(0, 1) == 1) begin
      restore_v = 1;
      restore_id = CkptID'(m_ids[$urandom_range(0, m_ids.size() - 1)]);
    end
    save = m_ids.size() < NUM_CKPT && $urandom_range(0, 2) == 0;
    save_slot = 2'($urandom_range(0, 3));
    free = m_ids.size() > 0 && $urandom_range(0, 3) == 0 && !(mispred && restore_v && m_ids[0] == int'(restore_id));
  endtask
  initial begin
    clear_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    // bypass: slot 0 maps x5->0x12, lookup 2 sees it, lookup 1 does not
    is_v[0] = 1; is_id[0] = 5; is_tag[0] = 7'h12; is_av[0] = 0;
    lk_id[1] = 5; lk_id[2] = 5;
    #2;
    cmp("byp_lk2_tag", int'(lk_tag[2]), 'h12);
    cmp("byp_lk2_avail", int'(lk_av[2]), 0);
    cmp("byp_lk1_tag", int'(lk_tag[1]), 'h40);
    cmp("byp_lk1_avail", int'(lk_av[1]), 1);
    cmp("ckptID_init", int'(ckpt_id), 0);
    tick();
    clear_in();
    lk_id[0] = 5;
    #2 cmp("x5_busy", int'(lk_av[0]), 0);
    wb_v[0] = 1; wb_tag[0] = 7'h12;
    #1 cmp("wb_same_cycle", int'(lk_av[0]), 1);
    tick();
    clear_in();
    lk_id[0] = 5;
    #2 cmp("wb_next_cycle", int'(lk_av[0]), 1);
    // checkpoint at slot 1 sees x3->0x20 but not slot 2's x3->0x21
    is_v[1] = 1; is_id[1] = 3; is_tag[1] = 7'h20;
    is_v[2] = 1; is_id[2] = 3; is_tag[2] = 7'h21;
    save = 1; save_slot = 1;
    tick();
    clear_in();
    lk_id[0] = 3;
    #2 cmp("x3_after_issue", int'(lk_tag[0]), 'h21);
    is_v[0] = 1; is_id[0] = 3; is_tag[0] = 7'h30;
    tick();
    clear_in();
    lk_id[0] = 3;
    #2 cmp("x3_later", int'(lk_tag[0]), 'h30);
    mispred = 1; restore_v = 1; restore_id = 0;
    tick();
    clear_in();
    lk_id[0] = 3;
    #2;
    cmp("x3_restored", int'(lk_tag[0]), 'h20);
    cmp("tail_after_restore", int'(ckpt_id), 1);
    for (int s = 0; s < 3; s++) begin
      save = 1;
      tick();
      clear_in();
      if (s == 1) #2 cmp("not_full_3", int'(full), 0);
    end
    #2;
    cmp("full_4", int'(full), 1);
    cmp("tail_wrap", int'(ckpt_id), 0);
    free = 1;
    tick();
    clear_in();
    #2;
    cmp("full_after_free", int'(full), 0);
    cmp("tail_after_free", int'(ckpt_id), 0);
    // mispredict without checkpoint: map falls back to committed state plus the commit
    mispred = 1; cm_v[0] = 1; cm_id[0] = 7; cm_tag[0] = 7'h05;
    #2 cmp("prev_x7", int'(cm_prev[0]), 'h40);
    tick();
    clear_in();
    lk_id[0] = 7; lk_id[1] = 5; lk_id[2] = 3;
    #2;
    cmp("x7_commit", int'(lk_tag[0]), 'h05);
    cmp("x5_from_com", int'(lk_tag[1]), 'h40);
    cmp("x3_from_com", int'(lk_tag[2]), 'h40);
    cmp("full_after_discard", int'(full), 0);
    cmp("tail_eq_head", int'(ckpt_id), 1);
    for (int s = 0; s < 3; s++) begin
      save = 1;
      tick();
      clear_in();
    end
    rst = 1;
    chk_en = 0;
    model_reset();
    lk_id[0] = 5;
    #2;
    cmp("rst_full", int'(full), 0);
    cmp("rst_ckptID", int'(ckpt_id), 0);
    cmp("rst_x5_tag", int'(lk_tag[0]), 'h40);
    cmp("rst_x5_avail", int'(lk_av[0]), 1);
    @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    for (int c = 0; c < 3000; c++) begin
      rand_in();
      tick();
    end
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
